// File: rtl/game_timer_ctrl_pkg.sv
// Shared game definitions: state encoding, count width and default round timing.
// Also used by the game FSM and the score display.
package game_timer_ctrl_pkg;

  localparam int CNT_W = 7;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  localparam int DEF_START_SECS   = 60;
  localparam int DEF_MAX_SECS     = 99;
  localparam int DEF_BONUS_SECS   = 3;
  localparam int DEF_PENALTY_SECS = 5;

  typedef logic [CNT_W-1:0] secs_t;

  // Clamp a signed intermediate seconds value into 0..max_v.
  function automatic secs_t clamp_secs(input logic signed [8:0] v, input secs_t max_v);
    if (v < 9'sd0) return '0;
    if (v > $signed({2'b00, max_v})) return max_v;
    return v[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/game_timer_ctrl_bin2bcd.sv
// Combinational 7-bit binary (0..99) to two BCD digits.
// Shared with the score display.
module bin2bcd
  import game_timer_ctrl_pkg::*;
(
  input  logic [CNT_W-1:0] bin_i,
  output logic [3:0]       tens_o,
  output logic [3:0]       ones_o
);

  logic [CNT_W-1:0] rem;

  // Subtract-ten ladder; nine steps cover the full 0..99 range.
  always_comb begin
    rem    = bin_i;
    tens_o = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem    = rem - 7'd10;
        tens_o = tens_o + 4'd1;
      end
    end
    ones_o = rem[3:0];
  end

endmodule

// File: rtl/game_timer_ctrl.sv
// Round countdown controller: 1 Hz edge tick, start/pause/bonus/penalty,
// BCD display registers and timeout flag for the game FSM.
//
// state       | meaning
// ST_IDLE     | after reset, waiting for start
// ST_RUNNING  | counting down on ticks, adjustments applied
// ST_PAUSED   | count frozen, ticks and adjustments dropped
// ST_EXPIRED  | count reached 0, waiting for start
module game_timer_ctrl
  import game_timer_ctrl_pkg::*;
#(
  parameter int START_SECS   = DEF_START_SECS,
  parameter int MAX_SECS     = DEF_MAX_SECS,
  parameter int BONUS_SECS   = DEF_BONUS_SECS,
  parameter int PENALTY_SECS = DEF_PENALTY_SECS
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       timer_clk_i,
  input  logic       start_i,
  input  logic       pause_i,
  input  logic       correct_i,
  input  logic       wrong_i,
  output logic [3:0] time_tens_o,
  output logic [3:0] time_ones_o,
  output logic       running_o,
  output logic       paused_o,
  output logic       expired_o,
  output logic       timeout_pulse_o
);

  localparam secs_t             START_C   = CNT_W'(START_SECS);
  localparam secs_t             MAX_C     = CNT_W'(MAX_SECS);
  localparam logic signed [8:0] BONUS_S   = 9'(BONUS_SECS);
  localparam logic signed [8:0] PENALTY_S = 9'(PENALTY_SECS);

  logic [1:0]        state_q, state_d;
  secs_t             count_q, count_d;
  logic              timer_clk_q;
  logic              tick;
  logic              running_q, paused_q, expired_q;
  logic              timeout_q, timeout_d;
  logic [3:0]        tens_q, ones_q;
  logic signed [8:0] adj_sum;
  secs_t             adj_count;
  secs_t             bcd_in;
  logic [3:0]        bcd_tens, bcd_ones;

  assign tick = timer_clk_i & ~timer_clk_q;

  always_comb begin
    adj_sum = $signed({2'b00, count_q}) - $signed({8'd0, tick})
            + (correct_i ? BONUS_S : 9'sd0)
            - (wrong_i ? PENALTY_S : 9'sd0);
    adj_count = clamp_secs(adj_sum, MAX_C);
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUNNING;
          count_d = START_C;
        end
      end
      ST_RUNNING: begin
        if (start_i) begin
          count_d = START_C;
        end else if (pause_i) begin
          state_d = ST_PAUSED;
        end else begin
          count_d = adj_count;
          if (adj_count == '0) begin
            state_d   = ST_EXPIRED;
            timeout_d = 1'b1;
          end
        end
      end
      ST_PAUSED: begin
        if (start_i) begin
          state_d = ST_RUNNING;
          count_d = START_C;
        end else if (pause_i) begin
          state_d = ST_RUNNING;
        end
      end
      ST_EXPIRED: begin
        count_d = '0;
        if (start_i) begin
          state_d = ST_RUNNING;
          count_d = START_C;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = START_C;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    timer_clk_q <= timer_clk_i;
    if (rst_i) begin
      state_q   <= ST_IDLE;
      count_q   <= START_C;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
      expired_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      running_q <= (state_d == ST_RUNNING);
      paused_q  <= (state_d == ST_PAUSED);
      expired_q <= (state_d == ST_EXPIRED);
      timeout_q <= timeout_d;
    end
  end

  // Reset steers the start value into the converter so the display is valid right after reset.
  assign bcd_in = rst_i ? START_C : count_q;

  bin2bcd u_bin2bcd (
    .bin_i  (bcd_in),
    .tens_o (bcd_tens),
    .ones_o (bcd_ones)
  );

  always_ff @(posedge clk_i) begin
    tens_q <= bcd_tens;
    ones_q <= bcd_ones;
  end

  assign time_tens_o     = tens_q;
  assign time_ones_o     = ones_q;
  assign running_o       = running_q;
  assign paused_o        = paused_q;
  assign expired_o       = expired_q;
  assign timeout_pulse_o = timeout_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl: directed scenarios plus random traffic,
// compared against a seconds-level reference model.
module tb_game_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       timer_clk = 1'b0;
  logic       start = 1'b0, pause = 1'b0, correct = 1'b0, wrong = 1'b0;
  logic [3:0] time_tens, time_ones;
  logic       running, paused, expired, timeout_pulse;

  int total = 0;
  int bad   = 0;

  typedef enum {M_IDLE, M_RUN, M_HOLD, M_DONE} mmode_t;
  mmode_t m_mode = M_IDLE;
  int     m_cnt  = 60;
  int     m_disp = 60;
  bit     m_to   = 1'b0;
  bit     m_prev = 1'b0;

  game_timer_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .timer_clk_i     (timer_clk),
    .start_i         (start),
    .pause_i         (pause),
    .correct_i       (correct),
    .wrong_i         (wrong),
    .time_tens_o     (time_tens),
    .time_ones_o     (time_ones),
    .running_o       (running),
    .paused_o        (paused),
    .expired_o       (expired),
    .timeout_pulse_o (timeout_pulse)
  );

  always #5 clk = ~clk;

  wire [11:0] obs = {time_tens, time_ones, running, paused, expired, timeout_pulse};

  function automatic logic [11:0] exp_vec();
    return {4'(m_disp / 10), 4'(m_disp % 10),
            m_mode == M_RUN, m_mode == M_HOLD, m_mode == M_DONE, m_to};
  endfunction

  // One clock: drive inputs, take the edge, advance the reference model.
  task automatic step(input bit r, input bit s, input bit p, input bit c, input bit w, input bit tc);
    bit tk;
    int n;
    rst = r; start = s; pause = p; correct = c; wrong = w; timer_clk = tc;
    @(posedge clk);
    if (r) begin
      m_mode = M_IDLE; m_cnt = 60; m_disp = 60; m_to = 0;
    end else begin
      tk = tc && !m_prev;
      m_disp = m_cnt;
      m_to = 0;
      case (m_mode)
        M_IDLE: if (s) begin m_mode = M_RUN; m_cnt = 60; end
        M_RUN: begin
          if (s) m_cnt = 60;
          else if (p) m_mode = M_HOLD;
          else begin
            n = m_cnt - int'(tk) + (c ? 3 : 0) - (w ? 5 : 0);
            if (n < 0) n = 0;
            if (n > 99) n = 99;
            m_cnt = n;
            if (n == 0) begin m_mode = M_DONE; m_to = 1; end
          end
        end
        M_HOLD: begin
          if (s) begin m_mode = M_RUN; m_cnt = 60; end
          else if (p) m_mode = M_RUN;
        end
        M_DONE: if (s) begin m_mode = M_RUN; m_cnt = 60; end
      endcase
    end
    m_prev = tc;
    #1;
    start = 0; pause = 0; correct = 0; wrong = 0;
  endtask

  task automatic tick_pulse();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic goto_count(input int n);
    int guard = 0;
    if (m_mode != M_RUN) step(0, 1, 0, 0, 0, 0);
    while (m_cnt != n && guard < 300) begin
      if (m_cnt < n) step(0, 0, 0, 1, 0, 0);
      else tick_pulse();
      guard++;
    end
    total++;
    if (obs !== exp_vec() || guard >= 300) begin
      bad++;
      $display("FAIL goto_%0d: got %h want %h guard=%0d", n, obs, exp_vec(), guard);
    end
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    total++;
    if (obs !== 12'h600) begin bad++; $display("FAIL reset_state: got %h want %h", obs, 12'h600); end
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    total++;
    if (running !== 1'b1 || obs !== exp_vec()) begin
      bad++; $display("FAIL reset_start: got %h want %h", obs, exp_vec());
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1);
      total++;
      if ({time_tens, time_ones} !== 8'h60 || obs !== exp_vec()) begin
        bad++; $display("FAIL reset_no_tick: got %h want %h", obs, exp_vec());
      end
    end
    tick_pulse();
    step(0, 0, 0, 0, 0, 1);
    total++;
    if ({time_tens, time_ones} !== 8'h59) begin
      bad++; $display("FAIL reset_first_tick: got %h want 59", {time_tens, time_ones});
    end
  endtask

  task automatic test_countdown();
    int pulses = 0;
    step(0, 1, 0, 0, 0, 0);
    for (int e = 0; e < 60; e++) begin
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
        step(0, 0, 0, 0, 0, 0);
        pulses += int'(timeout_pulse);
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL countdown_lo e=%0d: got %h want %h", e, obs, exp_vec()); end
      end
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
        step(0, 0, 0, 0, 0, 1);
        pulses += int'(timeout_pulse);
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL countdown_hi e=%0d: got %h want %h", e, obs, exp_vec()); end
      end
    end
    step(0, 0, 0, 0, 0, 0);
    pulses += int'(timeout_pulse);
    total++;
    if (pulses != 1 || expired !== 1'b1 || {time_tens, time_ones} !== 8'h00) begin
      bad++; $display("FAIL countdown_end: pulses=%0d expired=%b digits=%h want 1/1/00", pulses, expired, {time_tens, time_ones});
    end
  endtask

  task automatic test_pause();
    goto_count(12);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick_pulse();
      total++;
      if (obs !== exp_vec() || paused !== 1'b1) begin bad++; $display("FAIL pause_hold: got %h want %h", obs, exp_vec()); end
    end
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    total++;
    if ({time_tens, time_ones} !== 8'h12 || paused !== 1'b1) begin
      bad++; $display("FAIL pause_frozen: got %h/%b want 12/1", {time_tens, time_ones}, paused);
    end
    step(0, 0, 1, 0, 0, 0);
    tick_pulse();
    step(0, 0, 0, 0, 0, 1);
    total++;
    if ({time_tens, time_ones} !== 8'h11 || running !== 1'b1 || obs !== exp_vec()) begin
      bad++; $display("FAIL pause_resume: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_saturate();
    goto_count(97);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    total++;
    if ({time_tens, time_ones} !== 8'h99 || obs !== exp_vec()) begin
      bad++; $display("FAIL sat_max: got %h want %h", obs, exp_vec());
    end
    goto_count(4);
    step(0, 0, 0, 0, 1, 0);
    total++;
    if (timeout_pulse !== 1'b1 || expired !== 1'b1 || obs !== exp_vec()) begin
      bad++; $display("FAIL sat_floor: got %h want %h", obs, exp_vec());
    end
    step(0, 0, 0, 0, 0, 0);
    total++;
    if ({time_tens, time_ones} !== 8'h00 || timeout_pulse !== 1'b0) begin
      bad++; $display("FAIL sat_floor_after: got %h want 00 pulse 0", {time_tens, time_ones});
    end
    goto_count(20);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1);
    total++;
    if ({time_tens, time_ones} !== 8'h17 || obs !== exp_vec()) begin
      bad++; $display("FAIL net_adjust: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_priority();
    int guard = 0;
    goto_count(30);
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    total++;
    if ({time_tens, time_ones} !== 8'h60 || running !== 1'b1 || paused !== 1'b0) begin
      bad++; $display("FAIL start_over_pause: got %h want 60 running", obs);
    end
    while (m_mode != M_DONE && guard < 40) begin
      step(0, 0, 0, 0, 1, 0);
      guard++;
    end
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    total++;
    if (running !== 1'b1 || expired !== 1'b0 || obs !== exp_vec()) begin
      bad++; $display("FAIL expired_restart: got %h want %h", obs, exp_vec());
    end
    step(0, 0, 0, 0, 0, 0);
    total++;
    if ({time_tens, time_ones} !== 8'h60) begin
      bad++; $display("FAIL expired_restart_digits: got %h want 60", {time_tens, time_ones});
    end
  endtask

  task automatic test_reset_mid();
    goto_count(25);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 1);
    total++;
    if (obs !== 12'h600 || obs !== exp_vec()) begin
      bad++; $display("FAIL reset_mid: got %h want %h", obs, 12'h600);
    end
    step(0, 0, 0, 0, 0, 1);
    total++;
    if (obs !== 12'h600) begin bad++; $display("FAIL reset_mid_idle: got %h want 600", obs); end
  endtask

  task automatic test_random();
    bit tc = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) tc = ~tc;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, tc);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL random i=%0d: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_saturate();
    test_priority();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
